// File: rtl/umips_skid_stage.sv
// Elastic pipeline register with a one-entry skid buffer between umips stages.
// Latency: one cycle from accepted push to out_valid when the output is free.
// Backpressure: in_ready and out_valid come straight from flops; in_ready drops only when the skid entry is occupied.
module umips_skid_stage #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic             r_out_valid;
    logic             r_skid_valid;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] r_skid_data;

    logic w_push;
    logic w_take;

    assign w_push = in_valid & r_in_ready & ~flush;
    assign w_take = r_out_valid & out_ready & ~stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_out_data   <= RESET_VAL;
            r_skid_data  <= RESET_VAL;
        end else if (flush) begin
            // Valid bits clear but payloads are kept so the data path never toggles on a flush.
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            case ({r_out_valid, r_skid_valid})
                2'b00: begin
                    if (w_push) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= in_data;
                    end
                end
                2'b10: begin
                    if (w_push && w_take) begin
                        r_out_data <= in_data;
                    end else if (w_push) begin
                        r_skid_valid <= 1'b1;
                        r_skid_data  <= in_data;
                        r_in_ready   <= 1'b0;
                    end else if (w_take) begin
                        r_out_valid <= 1'b0;
                    end
                end
                2'b11: begin
                    if (w_take) begin
                        r_out_data   <= r_skid_data;
                        r_skid_valid <= 1'b0;
                        r_in_ready   <= 1'b1;
                    end
                end
                default: begin
                    // Skid-only is unreachable; promote the skid entry to keep ordering intact.
                    r_out_valid  <= 1'b1;
                    r_out_data   <= r_skid_data;
                    r_skid_valid <= 1'b0;
                    r_in_ready   <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule
